// File: rtl/ttl_out_pkg.sv
// Shared constants for the TTL output stage: defaults and the field
// layout of the 128-bit event word coming out of the RTO core.
package ttl_out_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int CNT_W_DEF  = 32;
  localparam int TS_W       = 64;
  localparam int RTO_W      = 128;
  localparam int RTO_TS_HI  = 127;
  localparam int RTO_TS_LO  = 64;
  localparam int UPD_W      = 32;

  // Readback select width; a single channel still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ttl_edge_counter.sv
// Per-channel rising-edge counter. It keeps the previous output bit,
// counts 0->1 transitions, saturates at all-ones, and a clear
// overrides any increment in the same cycle.
module ttl_edge_counter
  import ttl_out_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             bit_in,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: track the bit, then clear > saturating increment > hold.
  always_comb begin
    prev_d = bit_in;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (bit_in && !prev_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ttl_out_stage.sv
// TTL output stage: latches event levels from the RTO core, delays them
// through a fixed compensation chain, applies the software override at the
// registered output, and keeps per-channel edge counters for readback.
module ttl_out_stage
  import ttl_out_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int OUT_DELAY = 0,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SEL_W     = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              counter_matched,
  input  logic [RTO_W-1:0]  rto_out,
  input  logic              override_en,
  input  logic [NUM_CH-1:0] override_value,
  input  logic              count_clear,
  input  logic [SEL_W-1:0]  count_sel,
  output logic [NUM_CH-1:0] ttl_out,
  output logic [CNT_W-1:0]  count_out,
  output logic [UPD_W-1:0]  update_count,
  output logic [TS_W-1:0]   last_timestamp
);

  localparam int PAD_N = 2 ** SEL_W;

  logic [NUM_CH-1:0] level_q, level_d;
  logic [TS_W-1:0]   last_ts_q, last_ts_d;
  logic [UPD_W-1:0]  upd_q, upd_d;
  logic [NUM_CH-1:0] ttl_q, ttl_d;
  logic [CNT_W-1:0]  count_out_q, count_out_d;
  logic [NUM_CH-1:0] chain_out;
  logic [CNT_W-1:0]  cnt_pad [PAD_N];

  // Bits between the levels and the timestamp carry nothing for this stage.
  logic unused_rto_bits;
  assign unused_rto_bits = ^rto_out[RTO_TS_LO-1:NUM_CH];

  // Event accept: levels and timestamp only move on a strobe; clear wins
  // over the event counter but not over the level/timestamp capture.
  always_comb begin
    level_d   = level_q;
    last_ts_d = last_ts_q;
    upd_d     = upd_q;
    if (counter_matched) begin
      level_d   = rto_out[NUM_CH-1:0];
      last_ts_d = rto_out[RTO_TS_HI:RTO_TS_LO];
      upd_d     = upd_q + 1'b1;
    end
    if (count_clear) begin
      upd_d = '0;
    end
  end

  // Latency-compensation chain; zero stages means a straight wire.
  generate
    if (OUT_DELAY == 0) begin : g_no_delay
      assign chain_out = level_q;
    end else begin : g_delay
      logic [NUM_CH-1:0] stage_q [OUT_DELAY];
      logic [NUM_CH-1:0] stage_d [OUT_DELAY];
      for (genvar gi = 0; gi < OUT_DELAY; gi++) begin : g_stage
        // Each stage takes the previous one (stage 0 takes the level register).
        always_comb begin
          stage_d[gi] = (gi == 0) ? level_q : stage_q[(gi == 0) ? 0 : gi-1];
        end
        // Stage register.
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) stage_q[gi] <= '0;
          else         stage_q[gi] <= stage_d[gi];
        end
      end
      assign chain_out = stage_q[OUT_DELAY-1];
    end
  endgenerate

  // Edge counters per channel, padded with zeros so out-of-range selects read 0.
  generate
    for (genvar gi = 0; gi < PAD_N; gi++) begin : g_cnt
      if (gi < NUM_CH) begin : g_ch
        ttl_edge_counter #(.CNT_W(CNT_W)) u_cnt (
          .clk    (clk),
          .resetn (resetn),
          .bit_in (ttl_q[gi]),
          .clear  (count_clear),
          .count  (cnt_pad[gi])
        );
      end else begin : g_pad
        assign cnt_pad[gi] = '0;
      end
    end
  endgenerate

  // Output mux (override bypasses the chain) and counter readback mux.
  always_comb begin
    ttl_d       = override_en ? override_value : chain_out;
    count_out_d = cnt_pad[count_sel];
  end

  // Top-level registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q     <= '0;
      last_ts_q   <= '0;
      upd_q       <= '0;
      ttl_q       <= '0;
      count_out_q <= '0;
    end else begin
      level_q     <= level_d;
      last_ts_q   <= last_ts_d;
      upd_q       <= upd_d;
      ttl_q       <= ttl_d;
      count_out_q <= count_out_d;
    end
  end

  assign ttl_out        = ttl_q;
  assign count_out      = count_out_q;
  assign update_count   = upd_q;
  assign last_timestamp = last_ts_q;

endmodule
